alien_fleet: RTL

Owns the invader formation. It keeps a 4×8 alive bitmap and the formation position on the 32×16 playfield, and marches the formation on game ticks. It compares the player's bullet against live aliens and produces the one-cycle `hit` strobe that the player stage consumes to stop the bullet and increment the score. It sits directly downstream of `player` (consumes `bullet_x/bullet_y/bullet_flying`, `start_debounced`) and upstream of the video renderer.

---
 rtl/invaders_pkg.sv | 20 ++
 rtl/fleet_extent.sv | 50 +++++
 rtl/alien_fleet.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/invaders_pkg.sv
// invaders_pkg
// Shared playfield geometry and the fleet state encoding used by the
// invader-formation logic. No ports; imported by alien_fleet and fleet_extent.
package invaders_pkg;

    localparam int GRID_W     = 32;
    localparam int GRID_H     = 16;
    localparam int FLEET_COLS = 8;
    localparam int FLEET_ROWS = 4;
    localparam int COL_PITCH  = 2;
    localparam int SHIP_ROW   = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MARCH   = 2'd1,
        CLEARED = 2'd2,
        LANDED  = 2'd3
    } fleet_state_t;

endpackage

// File: rtl/fleet_extent.sv
// fleet_extent
// Combinational extent finder for the 4x8 alive bitmap (bit = row*8 + col).
// Ports:
//   alive   in  32  alive bitmap
//   min_col out  3  lowest column holding a live alien (0 when empty)
//   max_col out  3  highest column holding a live alien (0 when empty)
//   max_row out  2  lowest-on-screen row holding a live alien (0 when empty)
//   empty   out  1  no live aliens
module fleet_extent
    import invaders_pkg::*;
(
    input  logic [31:0] alive,
    output logic [2:0]  min_col,
    output logic [2:0]  max_col,
    output logic [1:0]  max_row,
    output logic        empty
);

    logic [FLEET_COLS-1:0] col_occ;
    logic [FLEET_ROWS-1:0] row_occ;

    genvar gi;
    generate
        for (gi = 0; gi < FLEET_COLS; gi++) begin : g_col
            assign col_occ[gi] = alive[gi] | alive[FLEET_COLS + gi] |
                                 alive[2*FLEET_COLS + gi] | alive[3*FLEET_COLS + gi];
        end
        for (gi = 0; gi < FLEET_ROWS; gi++) begin : g_row
            assign row_occ[gi] = |alive[gi*FLEET_COLS +: FLEET_COLS];
        end
    endgenerate

    always_comb begin
        min_col = 3'd0;
        max_col = 3'd0;
        max_row = 2'd0;
        // Scan downward so the last assignment is the lowest occupied column.
        for (int i = FLEET_COLS - 1; i >= 0; i--) begin
            if (col_occ[i]) min_col = 3'(i);
        end
        for (int i = 0; i < FLEET_COLS; i++) begin
            if (col_occ[i]) max_col = 3'(i);
        end
        for (int i = 0; i < FLEET_ROWS; i++) begin
            if (row_occ[i]) max_row = 2'(i);
        end
        empty = ~|alive;
    end

endmodule

// File: rtl/alien_fleet.sv
// alien_fleet
// Owns the invader formation: alive bitmap, position and march direction on
// the 32x16 playfield. Marches on game ticks and turns the player's bullet
// into a one-cycle hit strobe.
// Ports:
//   clk_36MHz     in   1  system clock
//   reset         in   1  synchronous, active-low
//   enable        in   1  game-tick strobe
//   start         in   1  launches a wave from IDLE
//   clear         in   1  restore aliens, home position, back to IDLE
//   bullet_x/y    in 5/4 bullet cell
//   bullet_flying in   1  bullet valid
//   hit           out  1  one-cycle strobe: a live alien was struck
//   alive         out 32  alive bitmap, bit = row*8 + col
//   fleet_x/y     out 5/4 cell of alien (0,0)
//   fleet_dir     out  1  0 = right, 1 = left
//   wave_cleared  out  1  high while in CLEARED
//   landed        out  1  high while in LANDED
module alien_fleet
    import invaders_pkg::*;
#(
    parameter int STEP_TICKS = 8,
    parameter int START_Y    = 1
) (
    input  logic        clk_36MHz,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic        clear,
    input  logic [4:0]  bullet_x,
    input  logic [3:0]  bullet_y,
    input  logic        bullet_flying,
    output logic        hit,
    output logic [31:0] alive,
    output logic [4:0]  fleet_x,
    output logic [3:0]  fleet_y,
    output logic        fleet_dir,
    output logic        wave_cleared,
    output logic        landed
);

    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

    fleet_state_t state_reg, state_next;
    logic [31:0]  alive_reg, alive_next;
    logic [4:0]   fleet_x_reg, fleet_x_next;
    logic [3:0]   fleet_y_reg, fleet_y_next;
    logic         dir_reg, dir_next;
    logic [TW-1:0] tick_reg, tick_next;
    logic         hit_reg, hit_next;
    logic         cleared_reg, landed_reg;

    logic [2:0] min_col, max_col;
    logic [1:0] max_row;
    logic       empty;

    fleet_extent u_extent (
        .alive   (alive_reg),
        .min_col (min_col),
        .max_col (max_col),
        .max_row (max_row),
        .empty   (empty)
    );

    // Bullet offset from the formation origin; the extra MSB is the borrow.
    logic [5:0] dx;
    logic [4:0] dy;
    logic [4:0] hit_idx;
    logic       hit_cand;

    assign dx      = {1'b0, bullet_x} - {1'b0, fleet_x_reg};
    assign dy      = {1'b0, bullet_y} - {1'b0, fleet_y_reg};
    assign hit_idx = {dy[1:0], dx[3:1]};
    assign hit_cand = (state_reg == MARCH) && bullet_flying &&
                      !dx[5] && !dx[0] && (dx[4:0] <= 5'd14) &&
                      !dy[4] && (dy[3:0] <= 4'd3) &&
                      alive_reg[hit_idx];

    logic [5:0] right_edge, left_edge;
    logic [4:0] bottom_row;
    logic       at_ship;
    logic       step;

    assign right_edge = {1'b0, fleet_x_reg} + {2'b00, max_col, 1'b0};
    assign left_edge  = {1'b0, fleet_x_reg} + {2'b00, min_col, 1'b0};
    assign bottom_row = {1'b0, fleet_y_reg} + {3'b000, max_row};
    assign at_ship    = bottom_row >= 5'(SHIP_ROW);
    assign step       = (state_reg == MARCH) && enable && (tick_reg == TICK_LAST);

    always_ff @(posedge clk_36MHz) begin
        if (!reset || clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        alive_next   = alive_reg;
        fleet_x_next = fleet_x_reg;
        fleet_y_next = fleet_y_reg;
        dir_next     = dir_reg;
        tick_next    = tick_reg;
        hit_next     = 1'b0;

        case (state_reg)
            IDLE:  if (start) state_next = MARCH;
            MARCH: begin
                if (empty)        state_next = CLEARED;
                else if (at_ship) state_next = LANDED;
            end
            default: state_next = state_reg;
        endcase

        if (state_reg == MARCH) begin
            if (hit_cand) begin
                hit_next            = 1'b1;
                alive_next[hit_idx] = 1'b0;
            end
            if (enable) begin
                tick_next = (tick_reg == TICK_LAST) ? '0 : tick_reg + 1'b1;
            end
            // Extents come from alive_reg, so a same-cycle hit does not
            // change this step's edge decision.
            if (step) begin
                if ((!dir_reg && right_edge == 6'd31) ||
                    ( dir_reg && left_edge  == 6'd0)) begin
                    // Hold at the bottom row rather than wrap; the fleet is
                    // leaving MARCH by then anyway.
                    fleet_y_next = (fleet_y_reg == 4'(GRID_H - 1)) ? fleet_y_reg
                                                                    : fleet_y_reg + 1'b1;
                    dir_next     = ~dir_reg;
                end else if (!dir_reg) begin
                    fleet_x_next = fleet_x_reg + 1'b1;
                end else begin
                    fleet_x_next = fleet_x_reg - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_36MHz) begin
        if (!reset || clear) begin
            alive_reg   <= 32'hFFFF_FFFF;
            fleet_x_reg <= 5'd0;
            fleet_y_reg <= 4'(START_Y);
            dir_reg     <= 1'b0;
            tick_reg    <= '0;
            hit_reg     <= 1'b0;
            cleared_reg <= 1'b0;
            landed_reg  <= 1'b0;
        end else begin
            alive_reg   <= alive_next;
            fleet_x_reg <= fleet_x_next;
            fleet_y_reg <= fleet_y_next;
            dir_reg     <= dir_next;
            tick_reg    <= tick_next;
            hit_reg     <= hit_next;
            cleared_reg <= (state_next == CLEARED);
            landed_reg  <= (state_next == LANDED);
        end
    end

    assign hit          = hit_reg;
    assign alive        = alive_reg;
    assign fleet_x      = fleet_x_reg;
    assign fleet_y      = fleet_y_reg;
    assign fleet_dir    = dir_reg;
    assign wave_cleared = cleared_reg;
    assign landed       = landed_reg;

endmodule
